// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run/halt/single-step sequencer.
// The LED/debug mux decodes the exported state with these same encodings.
//   state_t : sequencer state (S_RST=0, S_HALT=1, S_RUN=2, S_STEP=3)
//   STATE_W : width of the exported state bus
package cpu_run_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RST  = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
//   clock : system clock
//   reset : asynchronous active-high reset
//   btn   : raw button level, asynchronous to clock
//   pulse : one-cycle pulse when the debounced level goes 0->1
// The debounced level changes only after DEB_CYCLES consecutive synchronized
// samples that differ from it, so a held button yields exactly one pulse.
module btn_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [1:0]  sync;
  logic        level;
  logic [19:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == DEB_CYCLES - 20'd1) begin
        level <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle MIPS core.
//   clock, reset        : system clock, asynchronous active-high reset
//   btn_run/step/halt   : raw board buttons (debounced internally)
//   pc, bp_addr, bp_en  : current PC, breakpoint address and compare enable
//   cpu_en              : core clock enable (combinational from state/bp_hit)
//   cpu_rst             : registered core reset hold
//   halted              : registered, 1 while in S_HALT
//   state               : current sequencer state
//   cycle_cnt           : saturating count of cycles with cpu_en=1
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000,
  parameter int unsigned RST_HOLD   = 4,
  parameter logic        START_RUN  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_halt,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  output logic        cpu_en,
  output logic        cpu_rst,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] cycle_cnt
);

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

  state_t      state_q, state_d;
  logic [7:0]  hold_cnt;
  logic        bp_skip;
  logic        bp_hit;
  logic        run_p, step_p, halt_p;
  logic [31:0] cnt_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clock(clock), .reset(reset), .btn(btn_run), .pulse(run_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clock(clock), .reset(reset), .btn(btn_step), .pulse(step_p)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_halt (
    .clock(clock), .reset(reset), .btn(btn_halt), .pulse(halt_p)
  );

  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    bp_hit  = 1'b0;
    unique case (state_q)
      S_RST: begin
        if (hold_cnt == HOLD_LAST) state_d = START_RUN ? S_RUN : S_HALT;
      end
      S_HALT: begin
        if (halt_p)      state_d = S_HALT;
        else if (step_p) state_d = S_STEP;
        else if (run_p)  state_d = S_RUN;
      end
      S_STEP: begin
        cpu_en  = 1'b1;
        state_d = S_HALT;
      end
      S_RUN: begin
        // The breakpoint instruction itself is not executed; bp_skip lets a
        // resume execute it once.
        bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
        cpu_en = !bp_hit;
        if (bp_hit || halt_p) state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_RST;
      cpu_rst  <= 1'b1;
      halted   <= 1'b0;
      hold_cnt <= '0;
      bp_skip  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cpu_rst <= (state_d == S_RST);
      halted  <= (state_d == S_HALT);
      if (state_q == S_RST) hold_cnt <= hold_cnt + 8'd1;
      if (state_q == S_HALT && state_d == S_RUN) bp_skip <= 1'b1;
      else if (state_q == S_RUN)                 bp_skip <= 1'b0;
      if (cpu_en && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign state     = state_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl (DEB_CYCLES=4, RST_HOLD=4).
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_run = 1'b0, btn_step = 1'b0, btn_halt = 1'b0;
  logic [31:0] pc = '0, bp_addr = '0;
  logic        bp_en = 1'b0;
  logic        cpu_en, cpu_rst, halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int failures = 0;

  cpu_run_ctrl #(.DEB_CYCLES(20'd4), .RST_HOLD(4), .START_RUN(1'b0)) dut (
    .clock(clock), .reset(reset),
    .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst), .halted(halted),
    .state(state), .cycle_cnt(cycle_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Advance negedges until state==target or the budget runs out.
  task automatic wait_state(input string tag, input state_t target, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (state == target) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_step();
    btn_step = 1'b1;
    cyc(8);
    btn_step = 1'b0;
    cyc(10);
  endtask

  initial begin
    int en_n;
    logic left_halt, seen_step, seen_run;

    // 1: reset values and hold sequence
    cyc(2);
    chk("rst_state", 32'(state), 32'(S_RST));
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("hold_state", 32'(state), 32'(S_RST));
      @(negedge clock);
    end
    chk("post_hold_state", 32'(state), 32'(S_HALT));
    chk("post_hold_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("post_hold_halted", 32'(halted), 32'd1);
    chk("post_hold_cpu_en", 32'(cpu_en), 32'd0);
    chk("post_hold_cnt", cycle_cnt, 32'd0);

    // 2: held step button gives exactly one enabled cycle
    en_n = 0;
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (cpu_en) en_n++;
    end
    btn_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (cpu_en) en_n++;
    end
    chk("step_en_cycles", 32'(en_n), 32'd1);
    chk("step_cnt", cycle_cnt, 32'd1);
    chk("step_back_halt", 32'(state), 32'(S_HALT));

    // 3: glitch rejected, held run accepted
    btn_run = 1'b1;
    cyc(2);
    btn_run = 1'b0;
    cyc(10);
    chk("glitch_state", 32'(state), 32'(S_HALT));
    btn_run = 1'b1;
    wait_state("run_enter", S_RUN, 20);
    chk("run_cnt0", cycle_cnt, 32'd1);
    chk("run_en", 32'(cpu_en), 32'd1);
    cyc(3);
    chk("run_cnt3", cycle_cnt, 32'd4);
    btn_run = 1'b0;
    cyc(10);
    chk("run_still", 32'(state), 32'(S_RUN));

    // 4: breakpoint halts before the instruction, resume skips it once
    bp_addr = 32'h40;
    bp_en   = 1'b1;
    pc      = 32'h3C;
    #1;
    chk("bp_miss_en", 32'(cpu_en), 32'd1);
    @(negedge clock);
    pc = 32'h40;
    #1;
    chk("bp_hit_en", 32'(cpu_en), 32'd0);
    @(negedge clock);
    chk("bp_halt_state", 32'(state), 32'(S_HALT));
    chk("bp_halted", 32'(halted), 32'd1);
    btn_run = 1'b1;
    wait_state("resume_enter", S_RUN, 20);
    chk("resume_en", 32'(cpu_en), 32'd1);
    cyc(1);
    chk("rehit_en", 32'(cpu_en), 32'd0);
    cyc(1);
    chk("rehit_halt", 32'(state), 32'(S_HALT));
    btn_run = 1'b0;
    cyc(10);

    // 5: pulse priority in S_HALT
    bp_en = 1'b0;
    left_halt = 1'b0;
    {btn_run, btn_step, btn_halt} = 3'b111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (state != S_HALT) left_halt = 1'b1;
    end
    {btn_run, btn_step, btn_halt} = 3'b000;
    cyc(10);
    chk("prio_all_halt", 32'(left_halt), 32'd0);
    seen_step = 1'b0;
    seen_run  = 1'b0;
    {btn_run, btn_step} = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (state == S_STEP) seen_step = 1'b1;
      if (state == S_RUN)  seen_run = 1'b1;
    end
    {btn_run, btn_step} = 2'b00;
    cyc(10);
    chk("prio_step_seen", 32'(seen_step), 32'd1);
    chk("prio_run_seen", 32'(seen_run), 32'd0);
    chk("prio_back_halt", 32'(state), 32'(S_HALT));

    // 6a: counter saturation
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    do_step();
    chk("sat_first", cycle_cnt, 32'hFFFF_FFFF);
    do_step();
    chk("sat_no_wrap", cycle_cnt, 32'hFFFF_FFFF);

    // 6b: asynchronous reset mid-run
    btn_run = 1'b1;
    wait_state("rerun_enter", S_RUN, 20);
    btn_run = 1'b0;
    cyc(3);
    chk("pre_reset_en", 32'(cpu_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("areset_en", 32'(cpu_en), 32'd0);
    chk("areset_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("areset_state", 32'(state), 32'(S_RST));
    chk("areset_cnt", cycle_cnt, 32'd0);
    chk("areset_halted", 32'(halted), 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(6);
    chk("rereset_halt", 32'(state), 32'(S_HALT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
